// File: rtl/barrel_shift_pipe.sv
// Pipelined barrel shifter: SLL/SRL/SRA; op 11 rotates right with BARREL_SFT_ROTATE_EN, else SRL.
// Latency: ceil(log2(WIDTH)/PIPE_EVERY) cycles, 1 beat/cycle with out_ready high.
// Backpressure: global stall, every stage holds (bubbles included) while out_valid & ~out_ready.
module barrel_shift_pipe #(
    parameter int WIDTH      = 32,
    parameter int PIPE_EVERY = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    input  logic [$clog2(WIDTH)-1:0] in_amt,
    input  logic [1:0]               in_op,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_zero
);

    localparam int LVL = $clog2(WIDTH);
    localparam int LAT = (LVL + PIPE_EVERY - 1) / PIPE_EVERY;

    typedef struct packed {
        logic             vld;
        logic [WIDTH-1:0] dat;
        logic [LVL-1:0]   amt;
        logic [1:0]       op;
    } beat_t;

    logic  adv;
    beat_t in_beat;
    beat_t last;

    // One mux level: shift by 2^k. SRA reads the current MSB, which still equals
    // the operand sign because earlier SRA levels only ever fill with that bit.
    function automatic logic [WIDTH-1:0] shift_lvl(
        input logic [WIDTH-1:0] d,
        input int               k,
        input logic [1:0]       op
    );
        logic [WIDTH-1:0] r;
        int               sh;
        sh = 1 << k;
        case (op)
            2'b00:   r = d << sh;
            2'b01:   r = d >> sh;
            2'b10:   r = $signed(d) >>> sh;
            default: begin
`ifdef BARREL_SFT_ROTATE_EN
                r = (d >> sh) | (d << (WIDTH - sh));
`else
                r = d >> sh;
`endif
            end
        endcase
        return r;
    endfunction

    assign adv      = out_ready | ~out_valid;
    assign in_ready = adv & ~rst;

    always_comb begin
        in_beat     = '0;
        in_beat.vld = in_valid;
        in_beat.dat = in_data;
        in_beat.amt = in_amt;
        in_beat.op  = in_op;
    end

    genvar s;
    generate
        for (s = 0; s < LAT; s++) begin : g_stg
            localparam int LO = s * PIPE_EVERY;
            localparam int HI = (LO + PIPE_EVERY > LVL) ? LVL : LO + PIPE_EVERY;

            beat_t src;
            beat_t nxt;
            beat_t q;

            if (s == 0) begin : g_first
                assign src = in_beat;
            end else begin : g_rest
                assign src = g_stg[s-1].q;
            end

            always_comb begin
                nxt = src;
                for (int k = LO; k < HI; k++) begin
                    if (src.amt[k]) begin
                        nxt.dat = shift_lvl(nxt.dat, k, src.op);
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    q <= '0;
                end else if (adv) begin
                    q <= nxt;
                end
            end
        end
    endgenerate

    assign last      = g_stg[LAT-1].q;
    assign out_valid = last.vld;
    assign out_data  = last.dat;
    assign out_zero  = (last.dat == '0);

    // Amount and op are fully consumed by the last stage's muxes.
    logic unused_tail;
    assign unused_tail = ^{last.amt, last.op};

endmodule

// File: tb/tb_barrel_shift_pipe.sv
// Directed-vector bench for barrel_shift_pipe (WIDTH=32, PIPE_EVERY=2, 3-cycle latency).
// Driver pushes hand-computed results into a scoreboard queue; a monitor pops on each output transfer.
module tb_barrel_shift_pipe;

    localparam int W   = 32;
    localparam int LAT = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic [4:0]    in_amt;
    logic [1:0]    in_op;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic          out_zero;

    barrel_shift_pipe #(.WIDTH(W), .PIPE_EVERY(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amt    (in_amt),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_zero  (out_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] dat;
        int           acc;
        bit           lat;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_chk  = 0;
    int   n_fail = 0;
    int   cyc    = 0;

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Presents one beat; latency is counted from the cycle the beat is presented and accepted.
    task automatic send(input logic [W-1:0] d, input logic [4:0] a, input logic [1:0] o,
                        input logic [W-1:0] e, input bit push, input bit lat);
        int waited;
        exp_t x;
        waited = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_amt   = a;
        in_op    = o;
        #1;
        while (!in_ready && waited < 200) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (!in_ready) begin
            n_chk++;
            n_fail++;
            $display("FAIL accept_timeout: in_ready stayed 0, expected 1 within 200 cycles");
            in_valid = 1'b0;
        end else if (push) begin
            x.dat = e;
            x.acc = cyc;
            x.lat = lat;
            sb.push_back(x);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        #2;
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_output: got 0x%08h, expected no output", out_data);
            end else begin
                mon_e = sb.pop_front();
                chk("out_data", out_data, mon_e.dat);
                chk("out_zero", W'(out_zero), W'(mon_e.dat == '0));
                if (mon_e.lat) chk("latency", W'(cyc), W'(mon_e.acc + LAT));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] rot_exp;
        int waited;
`ifdef BARREL_SFT_ROTATE_EN
        rot_exp = 32'h1000_000F;
`else
        rot_exp = 32'h0000_000F;
`endif
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_amt = '0; in_op = '0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_out_valid", W'(out_valid), 32'd0);
        chk("rst_out_data",  out_data,       32'd0);
        chk("rst_out_zero",  W'(out_zero),  32'd1);
        chk("rst_in_ready",  W'(in_ready),  32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Basic ops and boundaries
        send(32'h0000_0001, 5'd31, 2'b00, 32'h8000_0000, 1, 1);
        send(32'h8000_0000, 5'd4,  2'b10, 32'hF800_0000, 1, 1);
        send(32'h8000_0000, 5'd4,  2'b01, 32'h0800_0000, 1, 1);
        send(32'h8000_0000, 5'd31, 2'b10, 32'hFFFF_FFFF, 1, 1);
        send(32'h8000_0000, 5'd31, 2'b01, 32'h0000_0001, 1, 1);
        for (int o = 0; o < 4; o++) send(32'hDEAD_BEEF, 5'd0, 2'(o), 32'hDEAD_BEEF, 1, 1);
        send(32'h0000_00F1, 5'd4,  2'b11, rot_exp,       1, 1);
        send(32'h0000_0001, 5'd1,  2'b01, 32'h0000_0000, 1, 1);
        idle();
        repeat (4) @(negedge clk);

        // Back-to-back stream
        for (int i = 0; i < 8; i++) send(32'h0000_0001, 5'(i), 2'b00, 32'h1 << i, 1, 1);
        idle();
        repeat (4) @(negedge clk);

        // Fill under stall, then hold for 5 cycles
        out_ready = 1'b0;
        send(32'hA5A5_0000, 5'd8, 2'b01, 32'h00A5_A500, 1, 0);
        send(32'h1234_5678, 5'd4, 2'b00, 32'h2345_6780, 1, 0);
        send(32'h8000_0001, 5'd1, 2'b10, 32'hC000_0000, 1, 0);
        idle();
        waited = 0;
        while (!out_valid && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            chk("stall_in_ready",  W'(in_ready),  32'd0);
            chk("stall_out_valid", W'(out_valid), 32'd1);
            chk("stall_out_data",  out_data,      32'h00A5_A500);
        end
        out_ready = 1'b1;
        send(32'h0000_FFFF, 5'd16, 2'b00, 32'hFFFF_0000, 1, 0);
        idle();
        repeat (6) @(negedge clk);

        // Reset with two beats in flight
        send(32'h0000_0010, 5'd1, 2'b00, 32'h0000_0020, 0, 0);
        send(32'h0000_0011, 5'd2, 2'b00, 32'h0000_0044, 0, 0);
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("flush_in_ready",  W'(in_ready),  32'd0);
        chk("flush_out_valid", W'(out_valid), 32'd0);
        chk("flush_out_zero",  W'(out_zero),  32'd1);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            chk("post_rst_idle", W'(out_valid), 32'd0);
        end
        send(32'h0000_0003, 5'd2, 2'b00, 32'h0000_000C, 1, 1);
        idle();

        waited = 0;
        while (sb.size() != 0 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        chk("scoreboard_drained", W'(sb.size()), 32'd0);
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
